trap_sequencer: RTL and testbench

Consumer side of the interrupt/fault priority encoder: samples `irq`, `fault` and `trapnr`, and sequences the CPU into a trap. It stalls the pipeline, saves the exception PC, redirects fetch to a per-cause vector and pulses `deassert` back to the encoder. It then holds trap state until the handler returns, and halts on a fault taken inside a handler (double fault). The block sits between the priority encoder and the CPU fetch/PC logic.

---
 rtl/trap_sequencer.sv | 161 ++++++++++++++++
 tb/tb_trap_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Trap entry/exit sequencer: takes encoder requests and sequences the stall,
// vector redirect and return, with double faults halting the core.
module trap_sequencer #(
    parameter logic [15:0] VEC_BASE   = 16'h0010,
    parameter logic [15:0] VEC_STRIDE = 16'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq,
    input  logic        fault,
    input  logic [3:0]  trapnr,
    input  logic        int_enable,
    input  logic        instr_boundary,
    input  logic [15:0] pc_in,
    input  logic        handler_done,
    output logic        deassert,
    output logic        stall,
    output logic        pc_load,
    output logic [15:0] pc_load_addr,
    output logic [15:0] epc,
    output logic [1:0]  cause,
    output logic        in_trap,
    output logic        halted,
    output logic [7:0]  trap_count,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_ACK     = 3'd2,
        S_HANDLER = 3'd3,
        S_RETURN  = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    state_t      r_state, w_next_state;
    logic        r_deassert, w_deassert;
    logic        r_stall, w_stall;
    logic        r_pc_load, w_pc_load;
    logic [15:0] r_pc_load_addr, w_pc_load_addr;
    logic [15:0] r_epc, w_epc;
    logic [1:0]  r_cause, w_cause;
    logic        r_in_trap, w_in_trap;
    logic        r_halted, w_halted;
    logic [7:0]  r_trap_count, w_trap_count;
    logic        w_take;
    logic [1:0]  w_lowest;

    // Faults are unmasked; an empty trapnr is a spurious request and ignored.
    assign w_take = (fault | (irq & int_enable & instr_boundary)) & (trapnr != 4'b0000);

    always_comb begin
        if (trapnr[0])      w_lowest = 2'd0;
        else if (trapnr[1]) w_lowest = 2'd1;
        else if (trapnr[2]) w_lowest = 2'd2;
        else                w_lowest = 2'd3;
    end

    always_comb begin
        w_next_state   = r_state;
        w_deassert     = r_deassert;
        w_stall        = r_stall;
        w_pc_load      = r_pc_load;
        w_pc_load_addr = r_pc_load_addr;
        w_epc          = r_epc;
        w_cause        = r_cause;
        w_in_trap      = r_in_trap;
        w_halted       = r_halted;
        w_trap_count   = r_trap_count;
        case (r_state)
            S_IDLE: begin
                w_deassert = 1'b0;
                w_pc_load  = 1'b0;
                w_in_trap  = 1'b0;
                w_stall    = 1'b0;
                if (w_take) begin
                    w_next_state = S_CAPTURE;
                    w_stall      = 1'b1;
                    w_epc        = pc_in;
                    w_cause      = w_lowest;
                    if (r_trap_count != 8'hFF) w_trap_count = r_trap_count + 8'd1;
                end
            end
            S_CAPTURE: begin
                w_next_state   = S_ACK;
                w_deassert     = 1'b1;
                w_pc_load      = 1'b1;
                w_pc_load_addr = VEC_BASE + 16'(r_cause) * VEC_STRIDE;
            end
            S_ACK: begin
                w_next_state = S_HANDLER;
                w_deassert   = 1'b0;
                w_pc_load    = 1'b0;
                w_stall      = 1'b0;
                w_in_trap    = 1'b1;
            end
            S_HANDLER: begin
                // A fault inside the handler outranks a simultaneous return.
                if (fault) begin
                    w_next_state = S_HALT;
                    w_halted     = 1'b1;
                    w_stall      = 1'b1;
                    w_in_trap    = 1'b0;
                end else if (handler_done) begin
                    w_next_state   = S_RETURN;
                    w_pc_load      = 1'b1;
                    w_pc_load_addr = r_epc;
                    w_in_trap      = 1'b0;
                end
            end
            S_RETURN: begin
                w_next_state = S_IDLE;
                w_pc_load    = 1'b0;
            end
            S_HALT: begin
                w_deassert = 1'b0;
                w_pc_load  = 1'b0;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_deassert     <= 1'b0;
            r_stall        <= 1'b0;
            r_pc_load      <= 1'b0;
            r_pc_load_addr <= 16'h0000;
            r_epc          <= 16'h0000;
            r_cause        <= 2'd0;
            r_in_trap      <= 1'b0;
            r_halted       <= 1'b0;
            r_trap_count   <= 8'd0;
        end else begin
            r_state        <= w_next_state;
            r_deassert     <= w_deassert;
            r_stall        <= w_stall;
            r_pc_load      <= w_pc_load;
            r_pc_load_addr <= w_pc_load_addr;
            r_epc          <= w_epc;
            r_cause        <= w_cause;
            r_in_trap      <= w_in_trap;
            r_halted       <= w_halted;
            r_trap_count   <= w_trap_count;
        end
    end

    assign deassert     = r_deassert;
    assign stall        = r_stall;
    assign pc_load      = r_pc_load;
    assign pc_load_addr = r_pc_load_addr;
    assign epc          = r_epc;
    assign cause        = r_cause;
    assign in_trap      = r_in_trap;
    assign halted       = r_halted;
    assign trap_count   = r_trap_count;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: entry, masking, return, double fault,
// asynchronous reset, counter saturation and spurious requests.
module tb_trap_sequencer;

    logic        clk;
    logic        reset;
    logic        irq;
    logic        fault;
    logic [3:0]  trapnr;
    logic        int_enable;
    logic        instr_boundary;
    logic [15:0] pc_in;
    logic        handler_done;
    logic        deassert;
    logic        stall;
    logic        pc_load;
    logic [15:0] pc_load_addr;
    logic [15:0] epc;
    logic [1:0]  cause;
    logic        in_trap;
    logic        halted;
    logic [7:0]  trap_count;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    trap_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .irq            (irq),
        .fault          (fault),
        .trapnr         (trapnr),
        .int_enable     (int_enable),
        .instr_boundary (instr_boundary),
        .pc_in          (pc_in),
        .handler_done   (handler_done),
        .deassert       (deassert),
        .stall          (stall),
        .pc_load        (pc_load),
        .pc_load_addr   (pc_load_addr),
        .epc            (epc),
        .cause          (cause),
        .in_trap        (in_trap),
        .halted         (halted),
        .trap_count     (trap_count),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // advance to just after the next active edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; irq = 1'b0; fault = 1'b0; trapnr = 4'b0; int_enable = 1'b0;
        instr_boundary = 1'b0; pc_in = 16'h0; handler_done = 1'b0;
        repeat (3) tick();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", stall); end
        total++; if (deassert !== 1'b0) begin bad++; $display("FAIL rst_deassert: got %b want 0", deassert); end
        total++; if (pc_load !== 1'b0) begin bad++; $display("FAIL rst_pc_load: got %b want 0", pc_load); end
        total++; if (pc_load_addr !== 16'h0) begin bad++; $display("FAIL rst_addr: got %h want 0000", pc_load_addr); end
        total++; if (epc !== 16'h0) begin bad++; $display("FAIL rst_epc: got %h want 0000", epc); end
        total++; if (cause !== 2'd0) begin bad++; $display("FAIL rst_cause: got %0d want 0", cause); end
        total++; if (in_trap !== 1'b0) begin bad++; $display("FAIL rst_in_trap: got %b want 0", in_trap); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted: got %b want 0", halted); end
        total++; if (trap_count !== 8'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", trap_count); end
        total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fault_entry();
        fault = 1'b1; trapnr = 4'b0001; pc_in = 16'h0200;
        tick();  // edge N
        fault = 1'b0; trapnr = 4'b0;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL fe_stall: got %b want 1", stall); end
        total++; if (deassert !== 1'b0) begin bad++; $display("FAIL fe_deassert_early: got %b want 0", deassert); end
        total++; if (epc !== 16'h0200) begin bad++; $display("FAIL fe_epc: got %h want 0200", epc); end
        total++; if (cause !== 2'd0) begin bad++; $display("FAIL fe_cause: got %0d want 0", cause); end
        total++; if (trap_count !== 8'd1) begin bad++; $display("FAIL fe_count: got %0d want 1", trap_count); end
        tick();  // edge N+1
        total++; if (deassert !== 1'b1) begin bad++; $display("FAIL fe_deassert: got %b want 1", deassert); end
        total++; if (pc_load !== 1'b1) begin bad++; $display("FAIL fe_pc_load: got %b want 1", pc_load); end
        total++; if (pc_load_addr !== 16'h0010) begin bad++; $display("FAIL fe_vector: got %h want 0010", pc_load_addr); end
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL fe_stall_n1: got %b want 1", stall); end
        @(negedge clk);
        total++; if (deassert !== 1'b1) begin bad++; $display("FAIL fe_deassert_negedge: got %b want 1", deassert); end
        tick();  // edge N+2
        total++; if (in_trap !== 1'b1) begin bad++; $display("FAIL fe_in_trap: got %b want 1", in_trap); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL fe_stall_clr: got %b want 0", stall); end
        total++; if (deassert !== 1'b0) begin bad++; $display("FAIL fe_deassert_pulse: got %b want 0", deassert); end
        total++; if (pc_load !== 1'b0) begin bad++; $display("FAIL fe_pc_load_pulse: got %b want 0", pc_load); end
        handler_done = 1'b1;
        tick();
        handler_done = 1'b0;
        total++; if (pc_load !== 1'b1) begin bad++; $display("FAIL fe_ret_pc_load: got %b want 1", pc_load); end
        total++; if (pc_load_addr !== 16'h0200) begin bad++; $display("FAIL fe_ret_addr: got %h want 0200", pc_load_addr); end
        total++; if (in_trap !== 1'b0) begin bad++; $display("FAIL fe_ret_in_trap: got %b want 0", in_trap); end
        tick();
        total++; if (pc_load !== 1'b0) begin bad++; $display("FAIL fe_ret_pulse: got %b want 0", pc_load); end
        total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL fe_idle: got %0d want 0", dbg_state); end
    endtask

    task automatic test_irq_masking();
        irq = 1'b1; trapnr = 4'b1000; int_enable = 1'b0; instr_boundary = 1'b1; pc_in = 16'h0300;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++; if (stall !== 1'b0) begin bad++; $display("FAIL mask_ie0 cycle %0d: got %b want 0", i, stall); end
        end
        int_enable = 1'b1; instr_boundary = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (stall !== 1'b0) begin bad++; $display("FAIL mask_ib0 cycle %0d: got %b want 0", i, stall); end
        end
        instr_boundary = 1'b1;
        tick();
        irq = 1'b0; trapnr = 4'b0;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL irq_stall: got %b want 1", stall); end
        total++; if (cause !== 2'd3) begin bad++; $display("FAIL irq_cause: got %0d want 3", cause); end
        total++; if (epc !== 16'h0300) begin bad++; $display("FAIL irq_epc: got %h want 0300", epc); end
        total++; if (trap_count !== 8'd2) begin bad++; $display("FAIL irq_count: got %0d want 2", trap_count); end
        tick();
        total++; if (pc_load_addr !== 16'h001C) begin bad++; $display("FAIL irq_vector: got %h want 001c", pc_load_addr); end
        total++; if (deassert !== 1'b1) begin bad++; $display("FAIL irq_deassert: got %b want 1", deassert); end
        tick();
        total++; if (in_trap !== 1'b1) begin bad++; $display("FAIL irq_in_trap: got %b want 1", in_trap); end
    endtask

    task automatic test_back_to_back();
        // irq pending while the handler returns; must wait out RETURN, then be taken
        irq = 1'b1; trapnr = 4'b0100; int_enable = 1'b1; instr_boundary = 1'b1; pc_in = 16'h0400;
        handler_done = 1'b1;
        tick();  // edge M
        handler_done = 1'b0;
        total++; if (pc_load !== 1'b1) begin bad++; $display("FAIL b2b_pc_load: got %b want 1", pc_load); end
        total++; if (pc_load_addr !== 16'h0300) begin bad++; $display("FAIL b2b_ret_addr: got %h want 0300", pc_load_addr); end
        total++; if (in_trap !== 1'b0) begin bad++; $display("FAIL b2b_in_trap: got %b want 0", in_trap); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_no_stall_m: got %b want 0", stall); end
        tick();  // edge M+1 (RETURN -> IDLE, no sampling)
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_no_stall_m1: got %b want 0", stall); end
        total++; if (pc_load !== 1'b0) begin bad++; $display("FAIL b2b_pulse: got %b want 0", pc_load); end
        tick();  // edge M+2
        irq = 1'b0; trapnr = 4'b0;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL b2b_taken: got %b want 1", stall); end
        total++; if (cause !== 2'd2) begin bad++; $display("FAIL b2b_cause: got %0d want 2", cause); end
        total++; if (epc !== 16'h0400) begin bad++; $display("FAIL b2b_epc: got %h want 0400", epc); end
        tick();
        total++; if (pc_load_addr !== 16'h0018) begin bad++; $display("FAIL b2b_vector: got %h want 0018", pc_load_addr); end
        tick();
        total++; if (in_trap !== 1'b1) begin bad++; $display("FAIL b2b_in_trap2: got %b want 1", in_trap); end
        total++; if (trap_count !== 8'd3) begin bad++; $display("FAIL b2b_count: got %0d want 3", trap_count); end
    endtask

    task automatic test_double_fault();
        fault = 1'b1; trapnr = 4'b0001; handler_done = 1'b1;
        tick();
        fault = 1'b0; trapnr = 4'b0; handler_done = 1'b0;
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL df_halted: got %b want 1", halted); end
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL df_stall: got %b want 1", stall); end
        total++; if (in_trap !== 1'b0) begin bad++; $display("FAIL df_in_trap: got %b want 0", in_trap); end
        total++; if (pc_load !== 1'b0) begin bad++; $display("FAIL df_pc_load: got %b want 0", pc_load); end
        total++; if (dbg_state !== 3'd5) begin bad++; $display("FAIL df_state: got %0d want 5", dbg_state); end
        fault = 1'b1; trapnr = 4'b0010; irq = 1'b1; int_enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++; if (halted !== 1'b1 || deassert !== 1'b0 || pc_load !== 1'b0 || stall !== 1'b1)
                begin bad++; $display("FAIL df_hold cycle %0d: got h%b d%b p%b s%b want h1 d0 p0 s1", i, halted, deassert, pc_load, stall); end
        end
        total++; if (trap_count !== 8'd3) begin bad++; $display("FAIL df_count: got %0d want 3", trap_count); end
        total++; if (epc !== 16'h0400) begin bad++; $display("FAIL df_epc: got %h want 0400", epc); end
        fault = 1'b0; trapnr = 4'b0; irq = 1'b0;
        reset = 1'b0;
        #1;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL df_reset_halted: got %b want 0", halted); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL df_reset_stall: got %b want 0", stall); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        fault = 1'b1; trapnr = 4'b0010; pc_in = 16'h0500;
        tick();  // now in CAPTURE
        fault = 1'b0; trapnr = 4'b0;
        total++; if (dbg_state !== 3'd1) begin bad++; $display("FAIL rm_capture: got %0d want 1", dbg_state); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rm_stall: got %b want 0", stall); end
        total++; if (epc !== 16'h0) begin bad++; $display("FAIL rm_epc: got %h want 0000", epc); end
        total++; if (cause !== 2'd0) begin bad++; $display("FAIL rm_cause: got %0d want 0", cause); end
        total++; if (trap_count !== 8'd0) begin bad++; $display("FAIL rm_count: got %0d want 0", trap_count); end
        total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL rm_state: got %0d want 0", dbg_state); end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (pc_load !== 1'b0 || deassert !== 1'b0 || stall !== 1'b0)
                begin bad++; $display("FAIL rm_no_pulse cycle %0d: got p%b d%b s%b want p0 d0 s0", i, pc_load, deassert, stall); end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 260; i++) begin
            fault = 1'b1; trapnr = 4'b0001; pc_in = 16'(i);
            tick();
            fault = 1'b0; trapnr = 4'b0;
            tick();
            tick();
            handler_done = 1'b1;
            tick();
            handler_done = 1'b0;
            tick();
            if (i == 0) begin
                total++; if (trap_count !== 8'd1) begin bad++; $display("FAIL sat_first: got %0d want 1", trap_count); end
            end
            if (i == 253) begin
                total++; if (trap_count !== 8'd254) begin bad++; $display("FAIL sat_254: got %0d want 254", trap_count); end
            end
        end
        total++; if (trap_count !== 8'd255) begin bad++; $display("FAIL sat_final: got %0d want 255", trap_count); end
        total++; if (epc !== 16'd259) begin bad++; $display("FAIL sat_epc: got %h want 0103", epc); end
    endtask

    task automatic test_spurious();
        irq = 1'b1; int_enable = 1'b1; instr_boundary = 1'b1; trapnr = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (stall !== 1'b0 || dbg_state !== 3'd0)
                begin bad++; $display("FAIL spur_irq cycle %0d: got s%b st%0d want s0 st0", i, stall, dbg_state); end
        end
        irq = 1'b0; fault = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (stall !== 1'b0 || dbg_state !== 3'd0)
                begin bad++; $display("FAIL spur_fault cycle %0d: got s%b st%0d want s0 st0", i, stall, dbg_state); end
        end
        fault = 1'b0;
        total++; if (trap_count !== 8'd255) begin bad++; $display("FAIL spur_count: got %0d want 255", trap_count); end
    endtask

    initial begin
        test_reset();
        test_fault_entry();
        test_irq_masking();
        test_back_to_back();
        test_double_fault();
        test_reset_mid();
        test_saturation();
        test_spurious();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
